// File: rtl/dm_line_fill.sv
// dm_line_fill
//   Initiator-side controller between the CPU data port and the data memory.
//   Reads are served from a single 16-word line buffer on a hit. A miss issues
//   one DM read and captures the 16-word burst that comes back. Writes go
//   straight through to DM as single words and also patch the buffer when the
//   line is resident.
//
// Ports
//   clock, reset             : sole clock; asynchronous active-low reset
//   req_valid/write/addr/wdata, req_ready
//                            : CPU request handshake (accepted on valid && ready)
//   resp_valid, resp_rdata, resp_error
//                            : one-cycle completion pulse; read data is held
//                              between pulses
//   DM_enable/read/write, DM_address, DM_in
//                            : one-cycle DM command
//   DM_out, DM_ready         : burst data returned by DM
module dm_line_fill #(
  parameter int data_size  = 32,
  parameter int addr_size  = 12,
  parameter int WAIT_STATE = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic                 req_write,
  input  logic [addr_size-1:0] req_addr,
  input  logic [data_size-1:0] req_wdata,
  output logic                 req_ready,
  output logic                 resp_valid,
  output logic [data_size-1:0] resp_rdata,
  output logic                 resp_error,
  output logic                 DM_enable,
  output logic                 DM_read,
  output logic                 DM_write,
  output logic [addr_size-1:0] DM_address,
  output logic [data_size-1:0] DM_in,
  input  logic [data_size-1:0] DM_out,
  input  logic                 DM_ready
);

  localparam int TAG_W  = addr_size - 6;
  localparam int TCNT_W = $clog2(TIMEOUT) + 1;
  localparam int WCNT_W = $clog2(WAIT_STATE + 1) + 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RHIT  = 3'd1;
  localparam logic [2:0] RREQ  = 3'd2;
  localparam logic [2:0] RWAIT = 3'd3;
  localparam logic [2:0] RFILL = 3'd4;
  localparam logic [2:0] WREQ  = 3'd5;
  localparam logic [2:0] WWAIT = 3'd6;
  localparam logic [2:0] DONE  = 3'd7;

  logic [2:0]             state;
  logic [addr_size-1:2]   addr_q;      // word address of the request in flight
  logic [data_size-1:0]   wdata_q;
  logic                   line_valid;
  logic [TAG_W-1:0]       line_tag;
  logic [data_size-1:0]   line_buf [16];
  logic [TCNT_W-1:0]      tcnt;        // cycles spent waiting for the first beat
  logic [3:0]             beat;        // next buffer slot to fill
  logic [WCNT_W-1:0]      wait_cnt;    // write commit wait

  logic [TAG_W-1:0]       q_tag;
  logic [3:0]             q_idx;
  logic                   req_hit;
  logic                   wr_hit;

  // Byte-offset bits of the request address carry no information.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[1:0];

  assign q_tag   = addr_q[addr_size-1:6];
  assign q_idx   = addr_q[5:2];
  assign req_hit = line_valid && (req_addr[addr_size-1:6] == line_tag);
  assign wr_hit  = line_valid && (q_tag == line_tag);

  // Control state. Every DM command lives in a single state so each command
  // is a one-cycle pulse, and RREQ/WREQ are never entered back to back.
  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      line_valid <= 1'b0;
      line_tag   <= '0;
      tcnt       <= '0;
      beat       <= '0;
      wait_cnt   <= '0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q     <= req_addr[addr_size-1:2];
            wdata_q    <= req_wdata;
            resp_error <= 1'b0;
            if (req_write)    state <= WREQ;
            else if (req_hit) state <= RHIT;
            else              state <= RREQ;
          end
        end
        RHIT: begin
          resp_rdata <= line_buf[q_idx];
          state      <= DONE;
        end
        RREQ: begin
          // The buffer is about to be overwritten; it is only trusted again
          // once all 16 beats have landed.
          line_valid <= 1'b0;
          tcnt       <= '0;
          state      <= RWAIT;
        end
        RWAIT: begin
          if (DM_ready) begin
            beat  <= 4'd1;
            state <= RFILL;
          end else if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
            resp_error <= 1'b1;
            state      <= DONE;
          end else begin
            tcnt <= tcnt + TCNT_W'(1);
          end
        end
        RFILL: begin
          if (!DM_ready) begin
            resp_error <= 1'b1;       // short burst: line stays invalid
            state      <= DONE;
          end else if (beat == 4'd15) begin
            line_valid <= 1'b1;
            line_tag   <= q_tag;
            // Word 15 is only on DM_out this cycle; the rest are buffered.
            resp_rdata <= (q_idx == 4'd15) ? DM_out : line_buf[q_idx];
            state      <= DONE;
          end else begin
            beat <= beat + 4'd1;
          end
        end
        WREQ: begin
          wait_cnt <= '0;
          state    <= WWAIT;
        end
        WWAIT: begin
          if (wait_cnt == WCNT_W'(WAIT_STATE)) state <= DONE;
          else                                 wait_cnt <= wait_cnt + WCNT_W'(1);
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Line buffer storage.
  // NOTE: the data array has no reset; line_valid alone says whether its
  // contents mean anything, so clearing 16 words would buy nothing.
  always_ff @(posedge clock) begin
    if (state == RWAIT && DM_ready)      line_buf[0]     <= DM_out;
    else if (state == RFILL && DM_ready) line_buf[beat]  <= DM_out;
    else if (state == WREQ && wr_hit)    line_buf[q_idx] <= wdata_q;
  end

  // Outputs decoded from state. Reset forces state to IDLE, so every DM
  // output drops at once; req_ready is also held low while reset is asserted.
  // NOTE: each output gets a default before the conditional assignments so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    DM_enable  = 1'b0;
    DM_read    = 1'b0;
    DM_write   = 1'b0;
    DM_address = '0;
    DM_in      = '0;
    case (state)
      IDLE: req_ready  = reset;
      DONE: resp_valid = 1'b1;
      RREQ: begin
        DM_enable  = 1'b1;
        DM_read    = 1'b1;
        DM_address = {q_tag, 6'b0};
      end
      WREQ: begin
        DM_enable  = 1'b1;
        DM_write   = 1'b1;
        DM_address = {addr_q, 2'b00};
        DM_in      = wdata_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dm_line_fill.sv
// tb_dm_line_fill
//   Directed bench for dm_line_fill. A behavioural DM answers commands with
//   bursts (normal, silent or truncated), a line-level reference model
//   predicts every response (data, error, completion cycle), and a single
//   negedge process compares DUT outputs against those predictions.
module tb_dm_line_fill;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int WS = 2;
  localparam int TO = 64;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr  = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_error;
  logic          DM_enable, DM_read, DM_write;
  logic [AW-1:0] DM_address;
  logic [DW-1:0] DM_in;
  logic [DW-1:0] DM_out   = '0;
  logic          DM_ready = 1'b0;

  dm_line_fill #(.data_size(DW), .addr_size(AW), .WAIT_STATE(WS), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .DM_enable(DM_enable), .DM_read(DM_read), .DM_write(DM_write),
    .DM_address(DM_address), .DM_in(DM_in),
    .DM_out(DM_out), .DM_ready(DM_ready)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- environment: data memory ----------------
  typedef enum int {DM_NORMAL, DM_SILENT, DM_DROP8} dm_mode_t;
  dm_mode_t      dm_mode = DM_NORMAL;
  logic [DW-1:0] dm_mem  [1024];
  logic [DW-1:0] ref_mem [1024];
  bit            burst_abort = 0;

  initial begin
    for (int i = 0; i < 1024; i++) dm_mem[i] = 32'hA000_0000 + i;
    for (int k = 0; k < 16; k++)   dm_mem[16 + k] = 32'h100 + k;
    for (int i = 0; i < 1024; i++) ref_mem[i] = dm_mem[i];
  end

  // Burst responder: first beat WS+2 cycles after the command cycle, then
  // consecutive beats (16, none, or 8 depending on the mode).
  initial begin
    int       base;
    int       nbeats;
    forever begin
      @(negedge clock);
      if (reset && DM_enable && DM_read) begin
        base        = {DM_address[11:6], 4'b0};
        nbeats      = (dm_mode == DM_NORMAL) ? 16 : (dm_mode == DM_DROP8) ? 8 : 0;
        burst_abort = 0;
        repeat (WS + 2) @(posedge clock);
        #1;
        for (int k = 0; k < nbeats; k++) begin
          if (burst_abort) break;
          DM_ready = 1'b1;
          DM_out   = dm_mem[base + k];
          @(posedge clock);
          #1;
        end
        DM_ready = 1'b0;
        DM_out   = '0;
      end
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    int            cyc;
    bit            is_read;
    bit            err;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  bit            m_valid = 0;
  logic [5:0]    m_tag   = '0;
  logic [DW-1:0] m_line  [16];

  // Predict the response of a request accepted in cycle n.
  task automatic predict(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int n, output int exp_en);
    exp_t       e;
    logic [5:0] t  = a[11:6];
    logic [3:0] ix = a[5:2];
    e.is_read = !w;
    e.err     = 0;
    e.data    = '0;
    if (w) begin
      exp_en = 1;
      e.cyc  = n + WS + 3;
      ref_mem[a[11:2]] = d;
      if (m_valid && m_tag == t) m_line[ix] = d;
    end else if (m_valid && m_tag == t) begin
      exp_en = 0;
      e.cyc  = n + 2;
      e.data = m_line[ix];
    end else begin
      exp_en  = 1;
      m_valid = 0;
      case (dm_mode)
        DM_NORMAL: begin
          for (int k = 0; k < 16; k++) m_line[k] = ref_mem[{t, k[3:0]}];
          m_valid = 1;
          m_tag   = t;
          e.data  = m_line[ix];
          e.cyc   = n + WS + 3 + 16;
        end
        DM_SILENT: begin e.err = 1; e.cyc = n + TO + 2; end
        default:   begin e.err = 1; e.cyc = n + WS + 4 + 8; end
      endcase
    end
    exp_q.push_back(e);
  endtask

  // ---------------- monitor / compare ----------------
  int            dm_en_cnt     = 0;
  logic [AW-1:0] last_dm_addr  = '0;
  bit            prev_en       = 0;
  logic [DW-1:0] last_rdata    = '0;
  int            last_resp_cyc = 0;
  exp_t          cur;

  always @(negedge clock) begin
    if (!reset) begin
      prev_en = 0;
    end else begin
      if (DM_enable) begin
        check("dm_enable_back_to_back", prev_en, 0);
        dm_en_cnt++;
        last_dm_addr = DM_address;
        if (DM_write) dm_mem[DM_address[11:2]] = DM_in;
      end else begin
        check("dm_rw_without_enable", {DM_read, DM_write}, 2'b00);
      end
      prev_en = DM_enable;
      if (resp_valid) begin
        check("resp_has_pending_request", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          check("resp_cycle", cyc, cur.cyc);
          check("resp_error", resp_error, cur.err);
          if (cur.is_read && !cur.err) check("resp_rdata", resp_rdata, cur.data);
        end
        last_rdata    = resp_rdata;
        last_resp_cyc = cyc;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // All helpers start and end just after a rising edge.
  task automatic wait_accept(output int n);
    bit ok = 0;
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      #1;
      if (req_ready) begin
        n  = cyc;
        ok = 1;
        break;
      end
    end
    check("accept_within_bound", ok, 1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      #2;
      if (exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    check("response_within_bound", ok, 1);
    @(posedge clock);
    #1;
  endtask

  task automatic do_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int n);
    int en0 = dm_en_cnt;
    int exp_en;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    wait_accept(n);
    predict(w, a, d, n, exp_en);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    wait_idle();
    check("dm_command_count", dm_en_cnt - en0, exp_en);
  endtask

  task automatic check_outputs_quiet(input string tag);
    check({tag, "_req_ready"},  req_ready, 0);
    check({tag, "_resp"},       {resp_valid, resp_error}, 2'b00);
    check({tag, "_resp_rdata"}, resp_rdata, 0);
    check({tag, "_dm_cmd"},     {DM_enable, DM_read, DM_write}, 3'b000);
    check({tag, "_dm_address"}, DM_address, 0);
    check({tag, "_dm_in"},      DM_in, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n, n2, en0, exp_en;

    #1;
    check_outputs_quiet("reset");
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("ready_after_reset", req_ready, 1);

    // Cold miss on the 0x040 line.
    do_req(0, 12'h044, '0, n);
    check("lit_miss_rdata",   last_rdata, 32'h101);
    check("lit_miss_latency", last_resp_cyc - n, 21);
    check("lit_miss_dm_addr", last_dm_addr, 12'h040);

    // Hit on the last word of the same line.
    do_req(0, 12'h07C, '0, n);
    check("lit_hit_rdata",   last_rdata, 32'h10F);
    check("lit_hit_latency", last_resp_cyc - n, 2);

    // Write-through, then hit on the written word.
    do_req(1, 12'h048, 32'hDEAD_BEEF, n);
    check("lit_write_latency", last_resp_cyc - n, 5);
    check("lit_write_dm_addr", last_dm_addr, 12'h048);
    check("lit_write_dm_data", dm_mem[12'h048 >> 2], 32'hDEAD_BEEF);
    do_req(0, 12'h048, '0, n);
    check("lit_write_then_hit", last_rdata, 32'hDEAD_BEEF);

    // Different line: refetch; byte offset bits ignored.
    do_req(0, 12'h08B, '0, n);
    check("lit_refetch_rdata", last_rdata, 32'hA000_0022);
    do_req(1, 12'h200, 32'h1234_5678, n);   // write to a non-resident line
    do_req(0, 12'h088, '0, n);              // still a hit on 0x080

    // DM never answers: timeout error, then the same line is fetched again.
    dm_mode = DM_SILENT;
    do_req(0, 12'h0C0, '0, n);
    check("lit_timeout_latency", last_resp_cyc - n, TO + 2);
    dm_mode = DM_NORMAL;
    do_req(0, 12'h0C4, '0, n);
    do_req(0, 12'h0C8, '0, n);

    // Burst stops after 8 beats: error, line remains invalid.
    dm_mode = DM_DROP8;
    do_req(0, 12'h104, '0, n);
    check("lit_short_burst_latency", last_resp_cyc - n, 14);
    dm_mode = DM_NORMAL;
    do_req(0, 12'h104, '0, n);
    do_req(0, 12'h200, '0, n);              // sees the earlier write-through

    // Request held while a miss is in progress.
    en0       = dm_en_cnt;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 12'h140;
    wait_accept(n);
    predict(0, 12'h140, '0, n, exp_en);
    @(posedge clock);
    #1;
    req_addr = 12'h17C;
    wait_accept(n2);
    check("held_accept_after_resp", n2, last_resp_cyc + 1);
    predict(0, 12'h17C, '0, n2, exp_en);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    wait_idle();
    check("held_single_dm_command", dm_en_cnt - en0, 1);

    // Reset in the middle of a fill.
    req_valid = 1'b1;
    req_addr  = 12'h180;
    wait_accept(n);
    predict(0, 12'h180, '0, n, exp_en);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    repeat (10) @(posedge clock);
    #2;
    reset       = 1'b0;
    burst_abort = 1;
    #1;
    check_outputs_quiet("mid_burst_reset");
    exp_q.delete();
    m_valid = 0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("ready_after_mid_reset", req_ready, 1);
    @(posedge clock);
    #1;
    do_req(0, 12'h144, '0, n);              // old line gone: miss
    check("lit_post_reset_miss_latency", last_resp_cyc - n, 21);
    do_req(0, 12'h180, '0, n);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
